// File: rtl/record_core_pkg.sv
// record_core_pkg: shared widths and state encoding for the audio recorder
package record_core_pkg;
  localparam int ADDR_W = 23;
  localparam int DATA_W = 32;
  typedef enum logic [1:0] {IDLE, WAIT_SAMPLE, WRITE_DATA, WRITE_LENGTH} rec_state_t;
endpackage

// File: rtl/record_core.sv
// record_core: streams audio samples to SDRAM as base+1.. and writes the sample count header at base
//   i_clk/i_rst: clock and sync active-high reset
//   rec_start/rec_select/rec_pause/rec_stop/rec_done: recording control and completion pulse
//   rec_write/rec_addr/rec_writedata/rec_sdram_finished: SDRAM write port with held request
//   rec_audio_valid/rec_audio_data/rec_audio_ready: sample stream handshake
module record_core
  import record_core_pkg::*;
#(
  parameter logic [ADDR_W-1:0] MAX_SAMPLES = 23'd1048576
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              rec_start,
  input  logic [ADDR_W-1:0] rec_select,
  input  logic              rec_pause,
  input  logic              rec_stop,
  output logic              rec_done,
  output logic              rec_write,
  output logic [ADDR_W-1:0] rec_addr,
  output logic [DATA_W-1:0] rec_writedata,
  input  logic              rec_sdram_finished,
  input  logic              rec_audio_valid,
  input  logic [DATA_W-1:0] rec_audio_data,
  output logic              rec_audio_ready
);
  rec_state_t        state;
  logic [ADDR_W-1:0] base;
  logic [ADDR_W-1:0] count;
  logic [ADDR_W-1:0] count_nx;
  logic [DATA_W-1:0] hold;
  logic              stop_pending;
  logic              ack_gap;
  // ack_gap keeps the header request low for one cycle after a data acknowledge,
  // so an acknowledge is never seen against two consecutive requests
  always_comb begin
    count_nx        = count + 1'b1;
    rec_audio_ready = state == WAIT_SAMPLE && !rec_pause && !rec_stop;
    rec_write       = state == WRITE_DATA || (state == WRITE_LENGTH && !ack_gap);
    rec_addr        = state == WRITE_DATA ? base + count_nx : state == WRITE_LENGTH ? base : '0;
    rec_writedata   = state == WRITE_DATA ? hold :
                      state == WRITE_LENGTH ? {{(DATA_W-ADDR_W){1'b0}}, count} : '0;
  end
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state        <= IDLE;
      base         <= '0;
      count        <= '0;
      hold         <= '0;
      stop_pending <= 1'b0;
      ack_gap      <= 1'b0;
      rec_done     <= 1'b0;
    end else begin
      rec_done <= 1'b0;
      ack_gap  <= 1'b0;
      case (state)
        IDLE: if (rec_start) begin
          base         <= rec_select;
          count        <= '0;
          stop_pending <= 1'b0;
          state        <= WAIT_SAMPLE;
        end
        WAIT_SAMPLE: if (rec_stop) state <= WRITE_LENGTH;
          else if (rec_audio_valid && rec_audio_ready) begin
            hold  <= rec_audio_data;
            state <= WRITE_DATA;
          end
        WRITE_DATA: if (rec_sdram_finished) begin
          count   <= count_nx;
          ack_gap <= 1'b1;
          state   <= (stop_pending || rec_stop || count_nx == MAX_SAMPLES) ? WRITE_LENGTH : WAIT_SAMPLE;
        end else if (rec_stop) stop_pending <= 1'b1;
        WRITE_LENGTH: if (rec_sdram_finished && !ack_gap) begin
          rec_done <= 1'b1;
          state    <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_record_core.sv
// tb_record_core: scoreboard bench for record_core with an SDRAM responder model
module tb_record_core;
  logic        clk = 1'b0;
  logic        rst;
  logic        rec_start;
  logic [22:0] rec_select;
  logic        rec_pause;
  logic        rec_stop;
  logic        rec_done;
  logic        rec_write;
  logic [22:0] rec_addr;
  logic [31:0] rec_writedata;
  logic        rec_sdram_finished;
  logic        rec_audio_valid;
  logic [31:0] rec_audio_data;
  logic        rec_audio_ready;

  int errors = 0;
  int checks = 0;
  int resp_delay = 0;
  int done_cnt = 0;
  int done_exp = 0;
  int wr_cycles = 0;
  int reuse_bad = 0;
  int obs_rd = 0;
  logic [54:0] exp_q[$];
  logic [54:0] obs_q[$];

  record_core #(.MAX_SAMPLES(23'd4)) dut (
    .i_clk(clk), .i_rst(rst), .rec_start(rec_start), .rec_select(rec_select),
    .rec_pause(rec_pause), .rec_stop(rec_stop), .rec_done(rec_done),
    .rec_write(rec_write), .rec_addr(rec_addr), .rec_writedata(rec_writedata),
    .rec_sdram_finished(rec_sdram_finished), .rec_audio_valid(rec_audio_valid),
    .rec_audio_data(rec_audio_data), .rec_audio_ready(rec_audio_ready)
  );

  initial forever #5 clk = ~clk;

  // SDRAM model: acknowledges a held request after resp_delay extra cycles and logs it
  initial begin
    int w;
    w = 0;
    rec_sdram_finished = 1'b0;
    forever begin
      @(negedge clk);
      if (rec_sdram_finished) begin
        rec_sdram_finished = 1'b0;
        if (rec_write) reuse_bad++;
      end else if (rec_write) begin
        w++;
        if (w > resp_delay) begin
          obs_q.push_back({rec_addr, rec_writedata});
          rec_sdram_finished = 1'b1;
          w = 0;
        end
      end else w = 0;
      if (rec_write) wr_cycles++;
      if (rec_done) done_cnt++;
    end
  end

  task automatic start_rec(input logic [22:0] b);
    rec_start = 1'b1;
    rec_select = b;
    @(posedge clk); #1;
    rec_start = 1'b0;
  endtask

  task automatic feed(input logic [22:0] b, input int idx, input logic [31:0] d);
    bit ok;
    ok = 0;
    rec_audio_valid = 1'b1;
    rec_audio_data = d;
    for (int i = 0; i < 50 && !ok; i++) begin
      @(negedge clk);
      if (rec_audio_ready) begin
        ok = 1;
        exp_q.push_back({b + 23'(idx + 1), d});
      end
      @(posedge clk); #1;
    end
    rec_audio_valid = 1'b0;
    checks++;
    if (!ok) begin errors++; $display("FAIL feed_accept idx=%0d got ready=0 want ready=1 within 50 cycles", idx); end
  endtask

  task automatic stop_rec(input logic [22:0] b, input int n);
    rec_stop = 1'b1;
    exp_q.push_back({b, 32'(n)});
    @(posedge clk); #1;
    rec_stop = 1'b0;
  endtask

  task automatic finish_rec(input string nm);
    int c;
    logic [54:0] e;
    done_exp++;
    c = 0;
    while (done_cnt < done_exp && c < 300) begin @(negedge clk); c++; end
    repeat (4) @(negedge clk);
    checks++;
    if (done_cnt !== done_exp) begin errors++; $display("FAIL %s_done got %0d pulse cycles want %0d", nm, done_cnt, done_exp); end
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      checks++;
      if (obs_rd >= obs_q.size()) begin
        errors++; $display("FAIL %s_write got none want addr=%h data=%h", nm, e[54:32], e[31:0]);
      end else begin
        if (obs_q[obs_rd] !== e) begin
          errors++;
          $display("FAIL %s_write got addr=%h data=%h want addr=%h data=%h", nm, obs_q[obs_rd][54:32], obs_q[obs_rd][31:0], e[54:32], e[31:0]);
        end
        obs_rd++;
      end
    end
    checks++;
    if (obs_q.size() != obs_rd) begin errors++; $display("FAIL %s_extra got %0d writes want %0d", nm, obs_q.size(), obs_rd); end
    obs_rd = obs_q.size();
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    rec_start = 1'b0; rec_select = '0; rec_pause = 1'b0; rec_stop = 1'b0;
    rec_audio_valid = 1'b0; rec_audio_data = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks++;
    if ({rec_write, rec_done, rec_audio_ready} !== 3'b0) begin errors++; $display("FAIL reset_ctrl got %b want 000", {rec_write, rec_done, rec_audio_ready}); end
    checks++;
    if ({rec_addr, rec_writedata} !== 55'd0) begin errors++; $display("FAIL reset_bus got addr=%h data=%h want 0", rec_addr, rec_writedata); end
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  task automatic test_basic();
    start_rec(23'h000100);
    feed(23'h000100, 0, 32'hA);
    feed(23'h000100, 1, 32'hB);
    feed(23'h000100, 2, 32'hC);
    stop_rec(23'h000100, 3);
    finish_rec("basic");
  endtask

  task automatic test_empty();
    start_rec(23'h000100);
    stop_rec(23'h000100, 0);
    finish_rec("empty");
  endtask

  task automatic test_pause();
    int bad;
    int wr0;
    bad = 0;
    wr0 = wr_cycles;
    start_rec(23'h000300);
    rec_pause = 1'b1;
    rec_audio_valid = 1'b1;
    rec_audio_data = 32'h55;
    repeat (10) begin
      @(negedge clk);
      if (rec_audio_ready) bad++;
      @(posedge clk); #1;
    end
    checks++;
    if (bad != 0) begin errors++; $display("FAIL pause_ready got %0d ready cycles want 0", bad); end
    checks++;
    if (wr_cycles != wr0) begin errors++; $display("FAIL pause_writes got %0d write cycles want 0", wr_cycles - wr0); end
    rec_pause = 1'b0;
    @(negedge clk);
    checks++;
    if (rec_audio_ready !== 1'b1) begin errors++; $display("FAIL pause_release got ready=%b want 1", rec_audio_ready); end
    exp_q.push_back({23'h000301, 32'h55});
    @(posedge clk); #1;
    rec_audio_valid = 1'b0;
    stop_rec(23'h000300, 1);
    finish_rec("pause");
  endtask

  task automatic test_stop_in_write();
    resp_delay = 5;
    start_rec(23'h000400);
    feed(23'h000400, 0, 32'h37);
    stop_rec(23'h000400, 1);
    finish_rec("stop_in_write");
    resp_delay = 0;
  endtask

  task automatic test_max_samples();
    int n;
    n = 0;
    start_rec(23'h000500);
    rec_audio_valid = 1'b1;
    rec_audio_data = 32'h100;
    for (int c = 0; c < 200 && n < 4; c++) begin
      @(negedge clk);
      if (rec_audio_ready) begin
        exp_q.push_back({23'h000500 + 23'(n + 1), rec_audio_data});
        n++;
      end
      @(posedge clk); #1;
      rec_audio_data = rec_audio_data + 1;
    end
    exp_q.push_back({23'h000500, 32'd4});
    finish_rec("max_samples");
    rec_audio_valid = 1'b0;
  endtask

  task automatic test_reset_mid();
    int d0;
    int o0;
    int wr0;
    resp_delay = 1000;
    start_rec(23'h000200);
    feed(23'h000200, 0, 32'h99);
    void'(exp_q.pop_back());
    rst = 1'b1;
    rec_audio_valid = 1'b1;
    @(negedge clk);
    checks++;
    if (rec_write !== 1'b1) begin errors++; $display("FAIL rst_mid_pre got write=%b want 1", rec_write); end
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if ({rec_write, rec_audio_ready, rec_addr} !== 25'd0) begin
      errors++; $display("FAIL rst_mid_idle got write=%b ready=%b addr=%h want 0 0 0", rec_write, rec_audio_ready, rec_addr);
    end
    d0 = done_cnt; o0 = obs_q.size(); wr0 = wr_cycles;
    rec_audio_valid = 1'b0;
    repeat (20) @(negedge clk);
    checks++;
    if (done_cnt != d0) begin errors++; $display("FAIL rst_mid_done got %0d pulses want 0", done_cnt - d0); end
    checks++;
    if (obs_q.size() != o0 || wr_cycles != wr0) begin
      errors++; $display("FAIL rst_mid_writes got %0d write cycles want 0", wr_cycles - wr0);
    end
    obs_rd = obs_q.size();
    @(posedge clk); #1;
    resp_delay = 0;
  endtask

  task automatic test_back_to_back();
    start_rec(23'h7FFFFE);
    feed(23'h7FFFFE, 0, 32'hDEAD0001);
    feed(23'h7FFFFE, 1, 32'hBEEF0002);
    stop_rec(23'h7FFFFE, 2);
    finish_rec("wrap");
    start_rec(23'h001000);
    feed(23'h001000, 0, 32'h12345678);
    stop_rec(23'h001000, 1);
    finish_rec("second");
    checks++;
    if (reuse_bad != 0) begin errors++; $display("FAIL ack_spacing got %0d held requests after ack want 0", reuse_bad); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_empty();
    test_pause();
    test_stop_in_write();
    test_max_samples();
    test_reset_mid();
    test_back_to_back();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
